// File: rtl/j11bus_pkg.sv
// Shared definitions for the J11 bus arbiter: state codes, master indices,
// bus widths and the request field bundle latched at grant.
package j11bus_pkg;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    wstrb;
        logic          gp;
        logic          irq;
        logic [1:0]    bs;
    } req_fields_t;

endpackage

// File: rtl/j11buswdog.sv
// Bus-cycle watchdog: counts WAIT cycles and flags expiry at TIMEOUT.
module j11buswdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clr) begin
            timer_d = '0;
        end else if (en) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire = (timer_q == TMAX);

endmodule

// File: rtl/j11busarb.sv
// Two-master (CPU / DMA) arbiter onto the shared slave bus, with DMA priority,
// a CPU starvation guard and an NXM watchdog for unacknowledged cycles.
module j11busarb
    import j11bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned MAXDMA  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [1:0]    m0_wstrb,
    input  logic          m0_gp,
    input  logic          m0_irq,
    input  logic [1:0]    m0_bs,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [1:0]    m1_wstrb,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic          m_nxm,
    output logic [DW-1:0] m_rdata,
    output logic          s_req,
    output logic          s_wr,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic [1:0]    s_wstrb,
    output logic          s_gp,
    output logic          s_irq,
    output logic [1:0]    s_bs,
    input  logic          s_ack,
    input  logic [DW-1:0] s_rdata,
    output logic          owner
);

    localparam int unsigned CW = (MAXDMA < 1) ? 1 : $clog2(MAXDMA + 1);
    localparam logic [CW-1:0] DMAX = CW'(MAXDMA);

    logic [1:0]    state_q, state_d;
    logic          pend0_q, pend0_d, pend1_q, pend1_d;
    logic [CW-1:0] dmacnt_q, dmacnt_d;
    logic          owner_q, owner_d;
    req_fields_t   fld_q, fld_d, cpu_fld, dma_fld;
    logic          s_req_q, s_req_d;
    logic          m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic          m_nxm_q, m_nxm_d;
    logic [DW-1:0] m_rdata_q, m_rdata_d;
    logic          wd_clr, wd_en, wd_expire;
    logic          done, done_nxm, grant_dma;

    j11buswdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // DMA cycles never carry CPU-only qualifiers.
    assign cpu_fld = '{wr: m0_wr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb,
                       gp: m0_gp, irq: m0_irq, bs: m0_bs};
    assign dma_fld = '{wr: m1_wr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb,
                       gp: 1'b0, irq: 1'b0, bs: 2'b00};

    always_comb begin
        state_d   = state_q;
        pend0_d   = pend0_q;
        pend1_d   = pend1_q;
        dmacnt_d  = dmacnt_q;
        owner_d   = owner_q;
        fld_d     = fld_q;
        s_req_d   = 1'b0;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m_nxm_d   = m_nxm_q;
        m_rdata_d = m_rdata_q;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        done      = 1'b0;
        done_nxm  = 1'b0;
        grant_dma = pend1_q && !(pend0_q && (dmacnt_q == DMAX));

        unique case (state_q)
            ST_IDLE: begin
                if (pend0_q || pend1_q) begin
                    owner_d = grant_dma ? M_DMA : M_CPU;
                    fld_d   = grant_dma ? dma_fld : cpu_fld;
                    if (!grant_dma) begin
                        dmacnt_d = '0;
                    end else if (pend0_q && (dmacnt_q != DMAX)) begin
                        dmacnt_d = dmacnt_q + 1'b1;
                    end
                    s_req_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_clr = 1'b1;
                if (s_ack) begin
                    done = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_en = !wd_expire;
                if (s_ack) begin
                    done = 1'b1;
                end else if (wd_expire) begin
                    done     = 1'b1;
                    done_nxm = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            state_d   = ST_IDLE;
            m_nxm_d   = done_nxm;
            m_rdata_d = done_nxm ? '0 : s_rdata;
            if (owner_q == M_DMA) begin
                m1_ack_d = 1'b1;
                pend1_d  = 1'b0;
            end else begin
                m0_ack_d = 1'b1;
                pend0_d  = 1'b0;
            end
        end

        // A new request on the completing edge re-arms the flag.
        if (m0_req) pend0_d = 1'b1;
        if (m1_req) pend1_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pend0_q   <= 1'b0;
            pend1_q   <= 1'b0;
            dmacnt_q  <= '0;
            owner_q   <= M_CPU;
            fld_q     <= '0;
            s_req_q   <= 1'b0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m_nxm_q   <= 1'b0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            pend0_q   <= pend0_d;
            pend1_q   <= pend1_d;
            dmacnt_q  <= dmacnt_d;
            owner_q   <= owner_d;
            fld_q     <= fld_d;
            s_req_q   <= s_req_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m_nxm_q   <= m_nxm_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign s_req   = s_req_q;
    assign s_wr    = fld_q.wr;
    assign s_addr  = fld_q.addr;
    assign s_wdata = fld_q.wdata;
    assign s_wstrb = fld_q.wstrb;
    assign s_gp    = fld_q.gp;
    assign s_irq   = fld_q.irq;
    assign s_bs    = fld_q.bs;
    assign m0_ack  = m0_ack_q;
    assign m1_ack  = m1_ack_q;
    assign m_nxm   = m_nxm_q;
    assign m_rdata = m_rdata_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_j11busarb.sv
// Scoreboard bench for j11busarb: a round-level grant-order model pushes expected
// transactions; a slave model answers s_req and a monitor checks grants and acks.
module tb_j11busarb;

    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned MAXDMA  = 4;
    localparam int unsigned NEVER   = 300;

    typedef struct {
        logic        mst;
        logic        wr;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wstrb;
        logic        gp;
        logic        irq;
        logic [1:0]  bs;
        int unsigned dly;
        logic [15:0] rdata;
        bit          rereq;
        bit          first;
        int unsigned reqcyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m0_req_stim = 1'b0, m1_req_stim = 1'b0, rereq = 1'b0;
    logic m0_req, m1_req;
    logic c_wr = 1'b0, c_gp = 1'b0, c_irq = 1'b0;
    logic [21:0] c_addr = '0, d_addr = '0;
    logic [15:0] c_wdata = '0, d_wdata = '0;
    logic [1:0]  c_wstrb = '0, c_bs = '0, d_wstrb = '0;
    logic d_wr = 1'b0;
    logic m0_ack, m1_ack, m_nxm, s_req, s_wr, s_gp, s_irq, owner;
    logic [15:0] m_rdata, s_wdata;
    logic [21:0] s_addr;
    logic [1:0]  s_wstrb, s_bs;
    logic s_ack_slv = 1'b0, s_ack_stray = 1'b0, s_ack;
    logic [15:0] s_rdata = '0;

    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;
    int unsigned n_acks = 0, n_sreq = 0;
    int unsigned last_ack_cyc = 0, sreq_cyc = 0;
    int unsigned mdl_cnt = 0;
    rec_t exp_q[$];
    int unsigned fdly[$];
    logic [15:0] frd[$];
    rec_t slv_cur;
    int unsigned slv_k = 0;
    bit slv_act = 1'b0;

    assign m0_req = m0_req_stim;
    assign m1_req = m1_req_stim | rereq;
    assign s_ack  = s_ack_slv | s_ack_stray;

    j11busarb #(.TIMEOUT(TIMEOUT), .MAXDMA(MAXDMA)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(c_wr), .m0_addr(c_addr), .m0_wdata(c_wdata),
        .m0_wstrb(c_wstrb), .m0_gp(c_gp), .m0_irq(c_irq), .m0_bs(c_bs),
        .m1_req(m1_req), .m1_wr(d_wr), .m1_addr(d_addr), .m1_wdata(d_wdata),
        .m1_wstrb(d_wstrb),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m_nxm(m_nxm), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_gp(s_gp), .s_irq(s_irq), .s_bs(s_bs),
        .s_ack(s_ack), .s_rdata(s_rdata), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [95:0] outs();
        return {m0_ack, m1_ack, m_nxm, m_rdata, s_req, s_wr, s_addr, s_wdata,
                s_wstrb, s_gp, s_irq, s_bs, owner};
    endfunction

    function automatic int unsigned pick_dly();
        if (fdly.size() != 0) return fdly.pop_front();
        if ($urandom_range(0, 15) == 0) return NEVER;
        return $urandom_range(0, 6);
    endfunction

    function automatic logic [15:0] pick_rd();
        if (frd.size() != 0) return frd.pop_front();
        return 16'($urandom);
    endfunction

    // Slave: acks dly cycles after s_req (never when dly exceeds the watchdog
    // window); a re-requesting DMA pulses m1_req in the completion cycle.
    initial begin
        forever begin
            @(negedge clk);
            s_ack_slv = 1'b0;
            rereq     = 1'b0;
            s_rdata   = 16'($urandom);
            if (rst) begin
                slv_act = 1'b0;
            end else begin
                if (s_req && exp_q.size() != 0) begin
                    slv_act = 1'b1;
                    slv_k   = 0;
                    slv_cur = exp_q[0];
                end else if (slv_act) begin
                    slv_k++;
                end
                if (slv_act) begin
                    if (slv_k == slv_cur.dly && slv_cur.dly <= TIMEOUT + 1) begin
                        s_ack_slv = 1'b1;
                        s_rdata   = slv_cur.rdata;
                    end
                    if (slv_k == ((slv_cur.dly > TIMEOUT + 1) ? TIMEOUT + 1 : slv_cur.dly)) begin
                        rereq   = slv_cur.rereq && slv_cur.mst;
                        slv_act = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares every s_req and every ack against the scoreboard head.
    initial begin
        rec_t r;
        bit   nxm;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (s_req) begin
                    n_sreq++;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_sreq actual=1 required=0 cyc=%0d", cyc);
                    end else begin
                        r = exp_q[0];
                        sreq_cyc = cyc;
                        check("sreq_cycle", cyc, r.first ? r.reqcyc + 2 : last_ack_cyc + 1);
                        check("owner", owner, r.mst);
                        check("s_fields", {s_wr, s_addr, s_wdata, s_wstrb, s_gp, s_irq, s_bs},
                              {r.wr, r.addr, r.wdata, r.wstrb, r.gp, r.irq, r.bs});
                    end
                end
                if (m0_ack || m1_ack) begin
                    n_acks++;
                    last_ack_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ack actual=%b%b required=00", m1_ack, m0_ack);
                    end else begin
                        r = exp_q.pop_front();
                        nxm = (r.dly > TIMEOUT + 1);
                        check("ack_master", {m1_ack, m0_ack}, r.mst ? 2'b10 : 2'b01);
                        check("ack_cycle", cyc, sreq_cyc + (nxm ? TIMEOUT + 2 : r.dly + 1));
                        check("nxm", m_nxm, nxm);
                        check("rdata", m_rdata, nxm ? 16'h0 : r.rdata);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL idle_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Grant order from the arbitration rules: DMA first unless the CPU has
    // already waited out MAXDMA DMA grants; nre DMA transactions re-request.
    task automatic round(input bit c, input bit d, input int unsigned nre, input bit wait_done);
        rec_t lst[$];
        rec_t r;
        bit p0 = c;
        bit p1 = d;
        int unsigned dgr = 0;
        while (p0 || p1) begin
            if (p1 && (!p0 || mdl_cnt != MAXDMA)) begin
                if (p0 && mdl_cnt < MAXDMA) mdl_cnt++;
                dgr++;
                r = '{mst: 1'b1, wr: d_wr, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb,
                      gp: 1'b0, irq: 1'b0, bs: 2'b00, dly: 0, rdata: 16'h0,
                      rereq: (dgr <= nre), first: 1'b0, reqcyc: 0};
                p1 = r.rereq;
            end else begin
                mdl_cnt = 0;
                p0 = 1'b0;
                r = '{mst: 1'b0, wr: c_wr, addr: c_addr, wdata: c_wdata, wstrb: c_wstrb,
                      gp: c_gp, irq: c_irq, bs: c_bs, dly: 0, rdata: 16'h0,
                      rereq: 1'b0, first: 1'b0, reqcyc: 0};
            end
            r.dly   = pick_dly();
            r.rdata = pick_rd();
            r.first = (lst.size() == 0);
            lst.push_back(r);
        end
        @(negedge clk);
        foreach (lst[i]) begin
            lst[i].reqcyc = cyc;
            exp_q.push_back(lst[i]);
        end
        m0_req_stim = c;
        m1_req_stim = d;
        @(negedge clk);
        m0_req_stim = 1'b0;
        m1_req_stim = 1'b0;
        if (wait_done) wait_idle();
    endtask

    task automatic rand_fields();
        c_wr = 1'($urandom); c_addr = 22'($urandom); c_wdata = 16'($urandom);
        c_wstrb = 2'($urandom); c_gp = 1'($urandom); c_irq = 1'($urandom);
        c_bs = 2'($urandom);
        d_wr = 1'($urandom); d_addr = 22'($urandom); d_wdata = 16'($urandom);
        d_wstrb = 2'($urandom);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout actual=%0d required=done", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int unsigned a0;
        int unsigned s0;
        bit c;
        bit d;
        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 96'h0);
        rst = 1'b0;
        @(negedge clk);

        // CPU read of the console register with GP/bank qualifiers.
        c_wr = 1'b0; c_addr = 22'o17777560; c_wdata = 16'h5a5a; c_wstrb = 2'b11;
        c_gp = 1'b1; c_irq = 1'b0; c_bs = 2'b10;
        fdly.push_back(3); frd.push_back(16'h1234);
        round(1'b1, 1'b0, 0, 1'b1);

        // DMA write with CPU qualifiers raised; they must not leak onto the bus.
        c_gp = 1'b1; c_irq = 1'b1; c_bs = 2'b11;
        d_wr = 1'b1; d_addr = 22'h3FFFFE; d_wdata = 16'hBEEF; d_wstrb = 2'b10;
        fdly.push_back(2);
        round(1'b0, 1'b1, 0, 1'b1);

        // Starvation guard: DMA x4, CPU, DMA.
        rand_fields();
        repeat (6) fdly.push_back($urandom_range(0, 4));
        round(1'b1, 1'b1, 4, 1'b1);

        // Timeout to NXM, then a stray ack in IDLE.
        rand_fields();
        fdly.push_back(NEVER);
        round(1'b1, 1'b0, 0, 1'b1);
        a0 = n_acks;
        s_ack_stray = 1'b1;
        @(negedge clk);
        s_ack_stray = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_ack", n_acks, a0);

        // Ack in the ISSUE cycle, and ack exactly at the watchdog limit.
        rand_fields();
        fdly.push_back(0);
        round(1'b1, 1'b0, 0, 1'b1);
        fdly.push_back(TIMEOUT + 1);
        round(1'b0, 1'b1, 0, 1'b1);

        // Reset while the slave stalls in WAIT abandons the cycle.
        rand_fields();
        fdly.push_back(NEVER);
        round(1'b1, 1'b0, 0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        mdl_cnt = 0;
        check("reset_mid_wait", outs(), 96'h0);
        @(negedge clk);
        rst = 1'b0;
        a0 = n_acks;
        s0 = n_sreq;
        repeat (20) @(negedge clk);
        check("reset_no_ack", n_acks, a0);
        check("reset_no_sreq", n_sreq, s0);
        rand_fields();
        round(1'b1, 1'b0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rand_fields();
            c = 1'($urandom);
            d = 1'($urandom) | !c;
            round(c, d, d ? $urandom_range(0, 5) : 0, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/j11busarb.md
# j11busarb

Two-master arbiter placed between the DCJ11 front-end bus port (master 0, CPU) and a DMA engine (master 1) on one side, and the shared memory/IO slave bus on the other. It captures one-cycle request pulses, grants by fixed DMA priority with a CPU starvation guard, and forwards a single-pulse request downstream. It routes the acknowledge and read data back to the owning master. A watchdog completes any cycle the slave never acknowledges, flagging it as non-existent memory (NXM).

## Interface
- TIMEOUT, 255: WAIT cycles before a cycle is forced complete with NXM.
- MAXDMA, 4: consecutive DMA grants allowed while the CPU is pending.
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  one-cycle request pulse.
- m0_wr, m1_wr  in  1  1 = write.
- m0_addr, m1_addr  in  22  physical address.
- m0_wdata, m1_wdata  in  16  write data.
- m0_wstrb, m1_wstrb  in  2  byte strobes.
- m0_gp, m0_irq  in  1  CPU general-purpose / interrupt-acknowledge cycle flags. Forced to 0 for DMA grants.
- m0_bs  in  2  CPU bank select. Forced to 0 for DMA grants.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m_nxm  out  1  valid with an ack; 1 = timed out.
- m_rdata  out  16  read data, valid with an ack.
- s_req  out  1  one-cycle request pulse to the slave.
- s_wr, s_addr[21:0], s_wdata[15:0], s_wstrb[1:0], s_gp, s_irq, s_bs[1:0]  out  latched request fields.
- s_ack  in  1  slave completion pulse.
- s_rdata  in  16  slave read data, valid with s_ack.
- owner  out  1  master of the current or last transaction.

## Operation
- Pending flags:
  - pend0 and pend1 are set by mN_req and cleared on the edge that issues mN_ack.
  - A req while the flag is already set is ignored.
- Masters hold all request fields stable from the req pulse until their ack. Fields are sampled at grant.
- State machine: IDLE, ISSUE, WAIT.
  - IDLE: if any pend flag is set, select a winner, latch its fields onto s_*, set owner, go to ISSUE.
  - ISSUE: s_req = 1, clear the timer. If s_ack, complete; otherwise go to WAIT.
  - WAIT: the timer increments each cycle.
    - On s_ack: complete.
    - Else when timer == TIMEOUT: complete with NXM.
- Complete:
  - Registered pulse on owner's mN_ack.
  - Normal completion: m_rdata = s_rdata, m_nxm = 0.
  - NXM completion: m_rdata = 0, m_nxm = 1.
  - Clear the owner's pend flag and return to IDLE.
- Arbitration:
  - Only pend1: grant DMA. Only pend0: grant CPU.
  - Both pending: grant DMA unless dmacnt == MAXDMA, in which case grant CPU.
  - dmacnt increments on each DMA grant made while pend0 = 1, saturates at MAXDMA, and clears on every CPU grant.
- s_ack in IDLE (a late ack after a timeout) is ignored.
- s_wdata and the other s_* fields hold their value until the next grant.

## Timing
- Reset values:
  - State: IDLE.
  - Flags and counters: pend0 = pend1 = 0, dmacnt = 0, timer = 0.
  - Outputs: all ack, s_req and m_nxm outputs 0; s_* fields 0; m_rdata 0; owner 0.
- Reset mid-transaction abandons the cycle; no ack is ever issued for it.
- Latency: req in cycle N sets pend at N+1, IDLE in N+1, s_req in N+2.
- mN_ack is high the cycle after s_ack is seen. Minimum req-to-ack is 3 cycles, when s_ack coincides with s_req.
- A new transaction may be granted in the cycle after the ack (IDLE), so there is no dead cycle beyond IDLE.
- NXM: s_req in cycle T, ack in cycle T + TIMEOUT + 2.
- s_ack and timeout in the same cycle: s_ack wins with normal data and nxm = 0.
- A req pulse in the same cycle as an ack for that master sets pend again, because the set takes priority over the clear.
- Timer width is $clog2(TIMEOUT+1).

## Structure
- Shared package j11bus_pkg holds:
  - the state encodings (IDLE, ISSUE, WAIT);
  - the master indices M_CPU = 0 and M_DMA = 1;
  - the address and data widths (22, 16).
- Optional sub-module j11buswdog: the timer with clear/enable inputs and an expire output. Everything else stays flat.

## Test plan
- CPU read 0o17777560: slave acks 3 cycles after s_req with 0x1234 → m0_ack one cycle later, m_rdata = 0x1234, m_nxm = 0, s_gp and s_bs mirror the CPU inputs.
- DMA write 0x3FFFFE, wdata 0xBEEF, wstrb 2'b10 → s_req one pulse with matching fields, s_gp = s_irq = 0, m1_ack after s_ack.
- Both masters pulse in the same cycle with continuous DMA re-requests, MAXDMA = 4 → grant order DMA ×4, CPU, then DMA.
- Slave never acks, TIMEOUT = 255 → owner ack at s_req + 257 with m_nxm = 1 and m_rdata = 0; a later stray s_ack in IDLE produces no ack.
- s_ack asserted in the ISSUE cycle → ack 3 cycles after req. s_ack on exactly timer == TIMEOUT → m_nxm = 0.
- rst pulsed while in WAIT → no m*_ack, all outputs 0, pend flags clear; the next req is serviced normally.
